// File: rtl/bcd_scan_pkg.sv
// Shared types and constants for the BCD scan driver.
//   state_t          : conversion FSM states
//   ONES..SIGN       : digit scan index values (bit position in an_n_o)
//   ITER_COUNT/CNT_W : double-dabble iteration count and its counter width
//   REFRESH_DIV_DEFAULT : clocks per digit slot
//   add3             : double-dabble nibble correction
package bcd_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [1:0] ONES     = 2'd0;
  localparam logic [1:0] TENS     = 2'd1;
  localparam logic [1:0] HUNDREDS = 2'd2;
  localparam logic [1:0] SIGN     = 2'd3;

  localparam int unsigned ITER_COUNT = 8;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned BCD_W      = 12;
  localparam int unsigned VAL_W      = 8;

  localparam int unsigned REFRESH_DIV_DEFAULT = 50000;

  // Pre-shift correction so a nibble >= 5 carries correctly after doubling.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? 4'(d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/bcd_dd_core.sv
// Iterative double-dabble datapath: 8-bit binary magnitude -> 12-bit BCD.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   start_i    : load mag_i, clear accumulator and iteration counter
//   step_i     : perform one add-3/shift iteration
//   mag_i      : unsigned magnitude to convert
//   bcd_o      : BCD accumulator {hundreds, tens, ones}
//   done_c     : combinational, high on the step that completes the 8th iteration
module bcd_dd_core
  import bcd_scan_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               step_i,
  input  logic [VAL_W-1:0]   mag_i,
  output logic [BCD_W-1:0]   bcd_o,
  output logic               done_c
);

  logic [BCD_W-1:0] bcd_q, bcd_d, adj;
  logic [VAL_W-1:0] mag_q, mag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // One iteration: correct every nibble, then shift {bcd, mag} left.
  always_comb begin
    bcd_d  = bcd_q;
    mag_d  = mag_q;
    cnt_d  = cnt_q;
    done_c = 1'b0;
    adj    = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    if (start_i) begin
      bcd_d = '0;
      mag_d = mag_i;
      cnt_d = '0;
    end else if (step_i) begin
      bcd_d  = {adj[BCD_W-2:0], mag_q[VAL_W-1]};
      mag_d  = {mag_q[VAL_W-2:0], 1'b0};
      cnt_d  = CNT_W'(cnt_q + CNT_W'(1));
      done_c = (cnt_q == CNT_W'(ITER_COUNT - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q <= '0;
      mag_q <= '0;
      cnt_q <= '0;
    end else begin
      bcd_q <= bcd_d;
      mag_q <= mag_d;
      cnt_q <= cnt_d;
    end
  end

  assign bcd_o = bcd_q;

endmodule

// File: rtl/bcd_scan_driver.sv
// Converts an 8-bit (optionally signed) result to decimal and time-multiplexes
// sign/hundreds/tens/ones onto a 4-digit display with leading-zero blanking.
// Ports:
//   clk, rst_n       : clock, async active-low reset
//   load_i           : capture value_i/signed_i and start conversion (ignored while busy)
//   value_i, signed_i: value to show; signed_i=1 treats value_i as two's complement
//   busy_o           : conversion in progress
//   nibble_o         : BCD digit of the active position
//   an_n_o           : active-low digit enables, bit0 = ones .. bit3 = sign
//   minus_o, blank_o : active digit shows "-" / is dark
//   lamp_test_i      : only when LAMP_TEST_EN is defined; forces all segments on
module bcd_scan_driver
  import bcd_scan_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [VAL_W-1:0] value_i,
  input  logic             signed_i,
`ifdef LAMP_TEST_EN
  input  logic             lamp_test_i,
`endif
  output logic             busy_o,
  output logic [3:0]       nibble_o,
  output logic [3:0]       an_n_o,
  output logic             minus_o,
  output logic             blank_o
);

  localparam int unsigned PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             neg_pend_q, neg_pend_d;
  logic [BCD_W-1:0] disp_bcd_q, disp_bcd_d;
  logic             disp_neg_q, disp_neg_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       nibble_q, nibble_d;
  logic [3:0]       an_n_q, an_n_d;
  logic             minus_q, minus_d;
  logic             blank_q, blank_d;

  logic             start_c, step_c, done_c, neg_c, tick_c;
  logic [VAL_W-1:0] mag_c;
  logic [BCD_W-1:0] core_bcd;
  logic [3:0]       hund, tens, ones;

  // Magnitude as 8-bit unsigned; -128 wraps to 128 which is what we want.
  assign neg_c = signed_i & value_i[VAL_W-1];
  assign mag_c = neg_c ? VAL_W'(~value_i + VAL_W'(1)) : value_i;

  bcd_dd_core u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_c),
    .step_i  (step_c),
    .mag_i   (mag_c),
    .bcd_o   (core_bcd),
    .done_c  (done_c)
  );

  // Conversion control: next state, core strobes and display commit.
  always_comb begin
    state_d    = state_q;
    neg_pend_d = neg_pend_q;
    disp_bcd_d = disp_bcd_q;
    disp_neg_d = disp_neg_q;
    start_c    = 1'b0;
    step_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_i) begin
          start_c    = 1'b1;
          neg_pend_d = neg_c;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        step_c = 1'b1;
        if (done_c) state_d = COMMIT;
      end
      COMMIT: begin
        disp_bcd_d = core_bcd;
        disp_neg_d = neg_pend_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      neg_pend_q <= 1'b0;
      disp_bcd_q <= '0;
      disp_neg_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      neg_pend_q <= neg_pend_d;
      disp_bcd_q <= disp_bcd_d;
      disp_neg_q <= disp_neg_d;
    end
  end

  // Free-running slot prescaler and digit index.
  always_comb begin
    tick_c  = (presc_q == PRESC_W'(REFRESH_DIV - 1));
    presc_d = tick_c ? '0 : PRESC_W'(presc_q + PRESC_W'(1));
    idx_d   = tick_c ? 2'(idx_q + 2'd1) : idx_q;
  end

  assign hund = disp_bcd_q[11:8];
  assign tens = disp_bcd_q[7:4];
  assign ones = disp_bcd_q[3:0];

  // Output decode with leading-zero blanking; defaults describe a dark digit.
  always_comb begin
    nibble_d = 4'd0;
    an_n_d   = 4'b1111;
    minus_d  = 1'b0;
    blank_d  = 1'b1;
    case (idx_q)
      ONES: begin
        nibble_d = ones;
        an_n_d   = 4'b1110;
        blank_d  = 1'b0;
      end
      TENS: begin
        if ((hund != 4'd0) || (tens != 4'd0)) begin
          nibble_d = tens;
          an_n_d   = 4'b1101;
          blank_d  = 1'b0;
        end
      end
      HUNDREDS: begin
        if (hund != 4'd0) begin
          nibble_d = hund;
          an_n_d   = 4'b1011;
          blank_d  = 1'b0;
        end
      end
      SIGN: begin
        if (disp_neg_q) begin
          minus_d = 1'b1;
          an_n_d  = 4'b0111;
          blank_d = 1'b0;
        end
      end
      default: ;
    endcase
`ifdef LAMP_TEST_EN
    if (lamp_test_i) begin
      nibble_d = 4'd8;
      an_n_d   = 4'b0000;
      minus_d  = 1'b0;
      blank_d  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= '0;
      idx_q    <= ONES;
      nibble_q <= 4'd0;
      an_n_q   <= 4'b1111;
      minus_q  <= 1'b0;
      blank_q  <= 1'b1;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      nibble_q <= nibble_d;
      an_n_q   <= an_n_d;
      minus_q  <= minus_d;
      blank_q  <= blank_d;
    end
  end

  assign busy_o   = busy_q;
  assign nibble_o = nibble_q;
  assign an_n_o   = an_n_q;
  assign minus_o  = minus_q;
  assign blank_o  = blank_q;

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Directed bench for bcd_scan_driver with REFRESH_DIV=4 (16-cycle scan frame).
// Define LAMP_TEST_EN to include the lamp-test port and its checks.
module tb_bcd_scan_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_i = 1'b0;
  logic [7:0] value_i = 8'd0;
  logic       signed_i = 1'b0;
`ifdef LAMP_TEST_EN
  logic       lamp_test_i = 1'b0;
`endif
  logic       busy_o;
  logic [3:0] nibble_o;
  logic [3:0] an_n_o;
  logic       minus_o;
  logic       blank_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bcd_scan_driver #(.REFRESH_DIV(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load_i),
    .value_i     (value_i),
    .signed_i    (signed_i),
`ifdef LAMP_TEST_EN
    .lamp_test_i (lamp_test_i),
`endif
    .busy_o      (busy_o),
    .nibble_o    (nibble_o),
    .an_n_o      (an_n_o),
    .minus_o     (minus_o),
    .blank_o     (blank_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse load for one edge; returns number of samples with busy high from that edge on.
  task automatic do_load(input logic [7:0] v, input logic s, output int busy_cyc);
    value_i  = v;
    signed_i = s;
    load_i   = 1'b1;
    step();
    load_i   = 1'b0;
    busy_cyc = 0;
    for (int i = 0; i < 30; i++) begin
      if (!busy_o) break;
      busy_cyc++;
      step();
    end
  endtask

  // Observe one full 16-cycle frame and check visible digits, values and blanking.
  task automatic scan(input string tag, input logic [3:0] exp_seen,
                      input logic [15:0] exp_nib, input logic exp_minus);
    logic [3:0]  seen;
    logic [15:0] nib;
    logic        minus_seen;
    int          blank_cnt, bad;
    seen = 4'b0; nib = 16'h0; minus_seen = 1'b0; blank_cnt = 0; bad = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      case (an_n_o)
        4'b1110: begin seen[0] = 1'b1; nib[3:0]   = nibble_o; end
        4'b1101: begin seen[1] = 1'b1; nib[7:4]   = nibble_o; end
        4'b1011: begin seen[2] = 1'b1; nib[11:8]  = nibble_o; end
        4'b0111: begin seen[3] = 1'b1; nib[15:12] = nibble_o; minus_seen = minus_o; end
        4'b1111: begin
          blank_cnt++;
          if (blank_o !== 1'b1 || nibble_o !== 4'd0 || minus_o !== 1'b0) bad++;
        end
        default: bad++;
      endcase
      if (an_n_o != 4'b1111 && blank_o !== 1'b0) bad++;
      if (an_n_o != 4'b1111 && an_n_o != 4'b0111 && minus_o !== 1'b0) bad++;
    end
    check({tag, "_seen"},  32'(seen), 32'(exp_seen));
    check({tag, "_nib"},   32'(nib), 32'(exp_nib));
    check({tag, "_minus"}, 32'(minus_seen), 32'(exp_minus));
    check({tag, "_blank"}, 32'(blank_cnt), 32'(4 * (4 - $countones(exp_seen))));
    check({tag, "_bad"},   32'(bad), 32'd0);
  endtask

  initial begin
    int bc;

    // Reset values while held
    step(); step();
    check("rst_busy",  32'(busy_o), 32'd0);
    check("rst_nib",   32'(nibble_o), 32'd0);
    check("rst_an",    32'(an_n_o), 32'hF);
    check("rst_minus", 32'(minus_o), 32'd0);
    check("rst_blank", 32'(blank_o), 32'd1);
    rst_n = 1'b1;
    scan("idle0", 4'b0001, 16'h0000, 1'b0);

    // 255 unsigned -> "255"
    do_load(8'd255, 1'b0, bc);
    check("busy255", 32'(bc), 32'd9);
    step();
    scan("v255", 4'b0111, 16'h0255, 1'b0);

    // -7 -> "-  7"
    do_load(8'hF9, 1'b1, bc);
    check("busyF9", 32'(bc), 32'd9);
    step();
    scan("vm7", 4'b1001, 16'h0007, 1'b1);

    // -128 signed, 128 unsigned
    do_load(8'h80, 1'b1, bc);
    step();
    scan("vm128", 4'b1111, 16'h0128, 1'b1);
    do_load(8'h80, 1'b0, bc);
    step();
    scan("v128", 4'b0111, 16'h0128, 1'b0);

    // 5 then 99 two cycles later while busy: 99 dropped
    value_i = 8'd5; signed_i = 1'b0; load_i = 1'b1;
    step();
    load_i = 1'b0;
    step();
    value_i = 8'd99; load_i = 1'b1;
    step();
    load_i = 1'b0;
    bc = 0;
    for (int i = 0; i < 30; i++) begin
      if (!busy_o) break;
      bc++;
      step();
    end
    check("drop_busy", 32'(bc), 32'd7);
    step(); step(); step();
    check("drop_idle", 32'(busy_o), 32'd0);
    scan("v5", 4'b0001, 16'h0005, 1'b0);

`ifdef LAMP_TEST_EN
    lamp_test_i = 1'b1;
    step();
    check("lamp_an",    32'(an_n_o), 32'h0);
    check("lamp_nib",   32'(nibble_o), 32'd8);
    check("lamp_blank", 32'(blank_o), 32'd0);
    check("lamp_minus", 32'(minus_o), 32'd0);
    lamp_test_i = 1'b0;
    step();
    check("lamp_off_an", 32'(an_n_o == 4'b1110 || an_n_o == 4'b1111), 32'd1);
    check("lamp_off_nib", 32'(nibble_o == 4'd5 || nibble_o == 4'd0), 32'd1);
    scan("lamp_off", 4'b0001, 16'h0005, 1'b0);
`endif

    // Reset mid-SHIFT after loading 200
    value_i = 8'd200; signed_i = 1'b0; load_i = 1'b1;
    step();
    load_i = 1'b0;
    step(); step();
    check("mid_busy_pre", 32'(busy_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_an",   32'(an_n_o), 32'hF);
    step();
    rst_n = 1'b1;
    scan("post_rst", 4'b0001, 16'h0000, 1'b0);
    check("post_rst_busy", 32'(busy_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
